// File: rtl/dram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_req_arbiter_if
// Brief    : Requester, response and DRAM FIFO signals shared by the arbiter.
// Revision : 1.0
// ============================================================================
interface dram_req_arbiter_if #(
  parameter int ADDR_W = 31
);
  logic [2:0]          req_valid;
  logic [2:0]          req_rnw;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*256-1:0]    req_wdata;
  logic [3*32-1:0]     req_wmask;
  logic [2:0]          req_ready;
  logic [2:0]          rsp_valid;
  logic [127:0]        rsp_data;
  logic [2:0]          rsp_ready;
  logic                af_full;
  logic                af_wr_en;
  logic [ADDR_W-1:0]   af_addr_din;
  logic [2:0]          af_cmd_din;
  logic                wdf_full;
  logic                wdf_wr_en;
  logic [127:0]        wdf_din;
  logic [15:0]         wdf_mask_din;
  logic                rdf_valid;
  logic [127:0]        rdf_dout;
  logic                rdf_rd_en;

  // Arbiter side: consumes requests, masters the DRAM FIFOs.
  modport master (
    input  req_valid, req_rnw, req_addr, req_wdata, req_wmask, rsp_ready,
    input  af_full, wdf_full, rdf_valid, rdf_dout,
    output req_ready, rsp_valid, rsp_data,
    output af_wr_en, af_addr_din, af_cmd_din, wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
  );

  modport slave (
    output req_valid, req_rnw, req_addr, req_wdata, req_wmask, rsp_ready,
    output af_full, wdf_full, rdf_valid, rdf_dout,
    input  req_ready, rsp_valid, rsp_data,
    input  af_wr_en, af_addr_din, af_cmd_din, wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
  );
endinterface
`default_nettype wire

// File: rtl/dram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_req_arbiter
// Brief    : Round-robin arbiter of three requesters onto the DRAM FIFOs with
//            in-order read return routing through an ID queue.
// Revision : 1.0
// ============================================================================
module dram_req_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int ADDR_W    = 31
) (
  input wire logic             clk,
  input wire logic             rst,
  dram_req_arbiter_if.master   bus
);
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int CNT_W  = TAG_AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WD0  = 2'd1,
    WD1  = 2'd2,
    CMD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         tag_mem_q [TAG_DEPTH];
  logic [1:0]         tag_mem_d [TAG_DEPTH];
  logic [TAG_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               beat_q, beat_d;

  logic [2:0] eligible;
  logic       found;
  logic [1:0] pick;
  logic [2:0] scan_sum;
  logic [1:0] scan_idx;
  logic       tag_full, tag_empty, tag_push, tag_pop;
  logic [1:0] head;

  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];
  assign eligible  = bus.req_valid & (~bus.req_rnw | {3{~tag_full}});
  assign bus.rsp_data = bus.rdf_dout;

  // Scan pointer, pointer+1, pointer+2 (mod 3) for the first eligible requester.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_q;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < 3; k++) begin
      scan_sum = {1'b0, ptr_q} + 3'(k);
      scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    grant_d          = grant_q;
    tag_push         = 1'b0;
    bus.req_ready    = '0;
    bus.af_wr_en     = 1'b0;
    bus.af_addr_din  = '0;
    bus.af_cmd_din   = '0;
    bus.wdf_wr_en    = 1'b0;
    bus.wdf_din      = '0;
    bus.wdf_mask_din = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_d = pick;
            state_d = bus.req_rnw[pick] ? CMD : WD0;
          end
        end
        WD0: begin
          bus.wdf_din      = bus.req_wdata[32'(grant_q)*256 +: 128];
          bus.wdf_mask_din = bus.req_wmask[32'(grant_q)*32 +: 16];
          bus.wdf_wr_en    = !bus.wdf_full;
          if (!bus.wdf_full) state_d = WD1;
        end
        WD1: begin
          bus.wdf_din      = bus.req_wdata[32'(grant_q)*256 + 128 +: 128];
          bus.wdf_mask_din = bus.req_wmask[32'(grant_q)*32 + 16 +: 16];
          bus.wdf_wr_en    = !bus.wdf_full;
          if (!bus.wdf_full) state_d = CMD;
        end
        CMD: begin
          bus.af_addr_din = bus.req_addr[32'(grant_q)*ADDR_W +: ADDR_W];
          bus.af_cmd_din  = {2'b00, bus.req_rnw[grant_q]};
          bus.af_wr_en    = !bus.af_full;
          if (!bus.af_full) begin
            bus.req_ready = 3'b001 << grant_q;
            ptr_d         = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
            tag_push      = bus.req_rnw[grant_q];
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read return: the queue head owns the next two beats from the read FIFO.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rdf_rd_en = 1'b0;
    if (!rst && bus.rdf_valid && !tag_empty) begin
      bus.rsp_valid = 3'b001 << head;
      bus.rdf_rd_en = bus.rsp_ready[head];
    end
    tag_pop   = bus.rdf_rd_en && beat_q;
    beat_d    = beat_q ^ bus.rdf_rd_en;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (tag_push) begin
      tag_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d            = wr_ptr_q + TAG_AW'(1);
    end
    if (tag_pop) rd_ptr_d = rd_ptr_q + TAG_AW'(1);
    unique case ({tag_push, tag_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      tag_mem_q <= tag_mem_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_req_arbiter
// Brief    : Scoreboard bench for dram_req_arbiter: arbitration table plus
//            write-stall, full-queue, response-stall and reset sequences.
// Revision : 1.0
// ============================================================================
module tb_dram_req_arbiter;
  localparam int ADDR_W    = 31;
  localparam int TAG_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_req_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  dram_req_arbiter #(.TAG_DEPTH(TAG_DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [1:0] id; logic [ADDR_W-1:0] addr; logic [2:0] cmd; } cmd_t;
  typedef struct packed { logic [127:0] data; logic [15:0] mask; } wd_t;
  typedef struct packed { logic [1:0] id; logic [127:0] data; } rsp_t;
  typedef struct packed { logic [2:0] valid; logic [2:0] rnw; logic [1:0] n; logic [1:0] o0, o1, o2; } arb_vec_t;

  cmd_t         exp_cmd [$];
  wd_t          exp_wd  [$];
  rsp_t         exp_rsp [$];
  logic [127:0] rdf_q   [$];
  int           rd_order [$];
  int           hold_cnt [3];
  int           beat_seq = 0;
  int           checks = 0;
  int           errors = 0;
  arb_vec_t     vecs [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_rdf();
    bus.rdf_valid = (rdf_q.size() != 0);
    bus.rdf_dout  = (rdf_q.size() != 0) ? rdf_q[0] : '0;
  endtask

  task automatic setup_req(input int i, input logic rnw, input logic [ADDR_W-1:0] addr,
                           input logic [255:0] wdata, input logic [31:0] wmask);
    bus.req_rnw[i]                   = rnw;
    bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.req_wdata[i*256 +: 256]      = wdata;
    bus.req_wmask[i*32 +: 32]        = wmask;
  endtask

  // Expected FIFO traffic for one transaction of requester i, in grant order.
  task automatic push_exp(input int i);
    cmd_t c;
    wd_t  w;
    c.id   = 2'(i);
    c.addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    c.cmd  = bus.req_rnw[i] ? 3'b001 : 3'b000;
    if (bus.req_rnw[i]) rd_order.push_back(i);
    else begin
      w.data = bus.req_wdata[i*256 +: 128];       w.mask = bus.req_wmask[i*32 +: 16];
      exp_wd.push_back(w);
      w.data = bus.req_wdata[i*256 + 128 +: 128]; w.mask = bus.req_wmask[i*32 + 16 +: 16];
      exp_wd.push_back(w);
    end
    exp_cmd.push_back(c);
  endtask

  task automatic stage_beats(input int pairs);
    rsp_t r;
    for (int k = 0; k < pairs; k++) begin
      if (rd_order.size() == 0) break;
      r.id = 2'(rd_order.pop_front());
      for (int b = 0; b < 2; b++) begin
        r.data = (128'(r.id) << 120) | 128'(32'hD000_0000 + beat_seq);
        beat_seq++;
        rdf_q.push_back(r.data);
        exp_rsp.push_back(r);
      end
    end
    drive_rdf();
  endtask

  // Sample and score the current cycle, then advance one clock.
  task automatic step();
    logic       pop;
    logic [2:0] rdy;
    cmd_t c;
    wd_t  w;
    rsp_t r;
    #1;
    pop = 1'b0;
    rdy = '0;
    if (!rst) begin
      if (bus.af_full)  chk("af_push_while_full", bus.af_wr_en, 1'b0);
      if (bus.wdf_full) chk("wdf_push_while_full", bus.wdf_wr_en, 1'b0);
      if (bus.af_wr_en) begin
        if (exp_cmd.size() == 0) chk("af_unexpected_push", 1, 0);
        else begin
          c = exp_cmd.pop_front();
          chk("af_addr", bus.af_addr_din, c.addr);
          chk("af_cmd", bus.af_cmd_din, c.cmd);
          chk("req_ready", bus.req_ready, 3'b001 << c.id);
        end
      end else chk("req_ready_idle", bus.req_ready, 3'b000);
      if (bus.wdf_wr_en) begin
        if (exp_wd.size() == 0) chk("wdf_unexpected_push", 1, 0);
        else begin
          w = exp_wd.pop_front();
          chk("wdf_data", bus.wdf_din, w.data);
          chk("wdf_mask", bus.wdf_mask_din, w.mask);
        end
      end
      if (bus.rdf_rd_en) begin
        if (exp_rsp.size() == 0) chk("rdf_unexpected_pop", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", bus.rsp_valid, 3'b001 << r.id);
          chk("rsp_data", bus.rsp_data, r.data);
          chk("rsp_ready_at_pop", bus.rsp_ready[r.id], 1'b1);
        end
      end
      pop = bus.rdf_rd_en;
      rdy = bus.req_ready;
    end
    @(posedge clk);
    #1;
    if (pop && rdf_q.size() != 0) void'(rdf_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (rdy[i]) begin
        if (hold_cnt[i] > 0) hold_cnt[i]--;
        else bus.req_valid[i] = 1'b0;
      end
    end
    drive_rdf();
  endtask

  task automatic drain_cmds(input int left, input int budget);
    int n = 0;
    while ((exp_cmd.size() > left || exp_wd.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("cmd_drain_left", exp_cmd.size(), left);
    chk("wdf_drain_left", exp_wd.size(), 0);
  endtask

  task automatic drain_rsp(input int budget);
    int n = 0;
    while (exp_rsp.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("rsp_drain_left", exp_rsp.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_af_wr_en"},  bus.af_wr_en,  1'b0);
    chk({tag, "_wdf_wr_en"}, bus.wdf_wr_en, 1'b0);
    chk({tag, "_rdf_rd_en"}, bus.rdf_rd_en, 1'b0);
    chk({tag, "_req_ready"}, bus.req_ready, 3'b000);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pairs;
    wd_t w;
    // {valid, rnw, count, grant order} with the pointer carried record to record
    vecs[0] = '{3'b111, 3'b111, 2'd3, 2'd0, 2'd1, 2'd2};
    vecs[1] = '{3'b010, 3'b000, 2'd1, 2'd1, 2'd0, 2'd0};
    vecs[2] = '{3'b101, 3'b000, 2'd2, 2'd2, 2'd0, 2'd0};
    vecs[3] = '{3'b111, 3'b010, 2'd3, 2'd1, 2'd2, 2'd0};
    vecs[4] = '{3'b011, 3'b011, 2'd2, 2'd1, 2'd0, 2'd0};
    vecs[5] = '{3'b100, 3'b100, 2'd1, 2'd2, 2'd0, 2'd0};

    rst = 1'b1;
    bus.req_valid = '0; bus.req_rnw = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0;
    bus.rsp_ready = 3'b111; bus.af_full = 1'b0; bus.wdf_full = 1'b0;
    bus.rdf_valid = 1'b0; bus.rdf_dout = '0;
    for (int i = 0; i < 3; i++) hold_cnt[i] = 0;
    repeat (3) step();
    chk_outputs_zero("reset");
    rst = 1'b0;
    #1;
    chk_outputs_zero("post_reset");

    // Read data with no outstanding tag must be ignored.
    rdf_q.push_back(128'hBAD);
    drive_rdf();
    repeat (3) begin
      step();
      chk("orphan_rd_en", bus.rdf_rd_en, 1'b0);
      chk("orphan_rsp_valid", bus.rsp_valid, 3'b000);
    end
    rdf_q.delete();
    drive_rdf();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++)
        if (vecs[r].valid[i])
          setup_req(i, vecs[r].rnw[i], ADDR_W'((r << 12) | ((i + 1) << 8)),
                    {96'h0, 8'(r), 8'(i), 16'hB1B1, 96'h0, 8'(r), 8'(i), 16'hA0A0},
                    {16'h1200 + 16'(r), 16'h00F0 | 16'(i)});
      for (int k = 0; k < int'(vecs[r].n); k++)
        push_exp(k == 0 ? int'(vecs[r].o0) : (k == 1 ? int'(vecs[r].o1) : int'(vecs[r].o2)));
      bus.req_valid = vecs[r].valid;
      drain_cmds(0, 100);
      pairs = rd_order.size();
      stage_beats(pairs);
      drain_rsp(100);
    end

    // Requesters 0 and 2 keep requesting writes: grants alternate, 1 is skipped.
    setup_req(0, 1'b0, 31'h0A00, {128'h0B, 128'h0A}, 32'h0F0F_F0F0);
    setup_req(2, 1'b0, 31'h2A00, {128'h2B, 128'h2A}, 32'h3333_CCCC);
    hold_cnt[0] = 1; hold_cnt[2] = 1;
    push_exp(0); push_exp(2); push_exp(0); push_exp(2);
    bus.req_valid = 3'b101;
    drain_cmds(0, 60);

    // Write data FIFO full for three cycles in WD0.
    setup_req(1, 1'b0, 31'h1B00, {128'hB, 128'hA}, 32'h0000_FFFF);
    push_exp(1);
    bus.wdf_full  = 1'b1;
    bus.req_valid = 3'b010;
    repeat (4) step();
    chk("wdf_held_while_full", exp_wd.size(), 2);
    bus.wdf_full = 1'b0;
    drain_cmds(0, 30);

    // Fill the ID queue; a read must wait while a write still gets through.
    setup_req(2, 1'b1, 31'h2000, '0, '0);
    hold_cnt[2] = 7;
    repeat (8) push_exp(2);
    bus.req_valid = 3'b100;
    drain_cmds(0, 100);
    setup_req(0, 1'b1, 31'h3000, '0, '0);
    setup_req(1, 1'b0, 31'h4000, {128'h44, 128'h43}, 32'h1111_2222);
    push_exp(1); push_exp(0);
    bus.req_valid = 3'b011;
    drain_cmds(1, 60);
    repeat (12) step();
    chk("full_read_not_issued", exp_cmd.size(), 1);
    stage_beats(1);
    drain_rsp(20);
    drain_cmds(0, 20);
    stage_beats(8);
    drain_rsp(100);

    // Consumer stalls: beat stays presented, no pop until rsp_ready returns.
    setup_req(0, 1'b1, 31'h5000, '0, '0);
    push_exp(0);
    bus.req_valid = 3'b001;
    drain_cmds(0, 20);
    bus.rsp_ready = 3'b110;
    stage_beats(1);
    repeat (5) begin
      step();
      chk("stall_rd_en", bus.rdf_rd_en, 1'b0);
      chk("stall_rsp_valid", bus.rsp_valid, 3'b001);
    end
    bus.rsp_ready = 3'b111;
    drain_rsp(20);

    // Reset in WD1 abandons the write; pointer restarts at requester 0.
    setup_req(0, 1'b0, 31'h6000, {128'h66, 128'h55}, 32'h0);
    w.data = 128'h55; w.mask = 16'h0;
    exp_wd.push_back(w);
    bus.req_valid = 3'b001;
    step();
    step();
    chk("wd1_beat0_pushed", exp_wd.size(), 0);
    rst = 1'b1;
    bus.req_valid = 3'b000;
    step();
    rst = 1'b0;
    #1;
    chk_outputs_zero("mid_txn_reset");
    setup_req(0, 1'b1, 31'h7000, '0, '0);
    setup_req(2, 1'b1, 31'h7200, '0, '0);
    push_exp(0); push_exp(2);
    bus.req_valid = 3'b101;
    drain_cmds(0, 20);
    stage_beats(2);
    drain_rsp(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
